data_memory_bytelane: RTL

//  Parametrised synchronous data memory for the MEM stage. Supports byte/half/word

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_load_align.sv | 32 +++
 rtl/data_memory_bytelane.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory.
//   SZ_*       : access size codes on the size port (2'b11 is illegal)
//   state_e    : INIT while the array is being cleared, IDLE once requests are accepted
//   lane_mask  : byte-write enables for a store of a given size at a given lane
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {INIT, IDLE} state_e;

  // Only meaningful for aligned accesses; misaligned requests never write.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lane;
      SZ_H:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load extraction: picks the byte or half at the given lane out of a 32-bit word
// and sign- or zero-extends it.
//   word        in  32  word read from the array
//   lane        in  2   byte address within the word
//   size        in  2   SZ_B / SZ_H / SZ_W
//   unsigned_ld in  1   1 = zero-extend, 0 = sign-extend
//   result      out 32  extended load value
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    // Halves are only legal at lanes 0 and 2; odd lanes are rejected upstream.
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    result = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// Synchronous data memory with little-endian byte lanes, sign/zero-extending
// loads, 1- or 2-cycle read latency and error reporting. After reset the array
// is swept to zero one word per cycle before ready rises.
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_read/mem_write  request strobes, sampled only while ready=1
//   addr, wdata, size   byte address, store data, access size
//   unsigned_ld         zero-extend (1) or sign-extend (0) sub-word loads
//   rdata/rdata_valid   load result (held between loads) and its one-cycle strobe
//   ready               clear sweep finished
//   err                 one-cycle pulse for a rejected request
//
// state | meaning
// INIT  | zeroing word sweep_idx each cycle; requests ignored
// IDLE  | array initialised; one request per cycle accepted
module data_memory_bytelane
  import dmem_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 256,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * 4);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sweep_idx_q, sweep_idx_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [ADDR_W-1:0]  offset;
  logic [IDX_W-1:0]   widx;
  logic [1:0]         lane;
  logic               req, bad;
  logic [DATA_W-1:0]  ld_aligned;

  logic               mem_we;
  logic [3:0]         mem_be;
  logic [IDX_W-1:0]   mem_widx;
  logic [DATA_W-1:0]  mem_wd;

  logic               ld_v_c, ld_e_c, st_e_c;
  logic [DATA_W-1:0]  ld_d_c;
  logic               ld_v_p_q, ld_v_p_d, ld_e_p_q, ld_e_p_d;
  logic [DATA_W-1:0]  ld_d_p_q, ld_d_p_d;
  logic               ld_v_f, ld_e_f;
  logic [DATA_W-1:0]  ld_d_f;

  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic               err_q, err_d;

  // Request decode. BASE_ADDR is word aligned, so the offset's low bits are the lane.
  always_comb begin
    offset = addr - BASE_ADDR;
    widx   = offset[IDX_W+1:2];
    lane   = offset[1:0];
    req    = (state_q == IDLE) && (mem_read || mem_write);
    bad    = ({1'b0, offset} >= SPAN)
          || (size == 2'b11)
          || ((size == SZ_H) && lane[0])
          || ((size == SZ_W) && (lane != 2'b00))
          || (mem_read && mem_write);
  end

  dmem_load_align u_align (
    .word        (mem_q[widx]),
    .lane        (lane),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .result      (ld_aligned)
  );

  // Array write port: the sweep owns it during INIT, good stores afterwards.
  always_comb begin
    mem_we   = 1'b0;
    mem_be   = 4'b0000;
    mem_widx = widx;
    mem_wd   = wdata;
    if (state_q == INIT) begin
      mem_we   = 1'b1;
      mem_be   = 4'b1111;
      mem_widx = sweep_idx_q;
      mem_wd   = '0;
    end else if (req && mem_write && !bad) begin
      mem_we = 1'b1;
      mem_be = lane_mask(size, lane);
      case (size)
        SZ_B:    mem_wd = {4{wdata[7:0]}};
        SZ_H:    mem_wd = {2{wdata[15:0]}};
        default: mem_wd = wdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_widx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      INIT: begin
        sweep_idx_d = sweep_idx_q + IDX_W'(1);
        if (sweep_idx_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: ;
    endcase
  end

  // Response path. Both-high requests count as bad stores: err at latency 1, no data.
  always_comb begin
    ld_v_c   = req && mem_read && !mem_write;
    ld_e_c   = ld_v_c && bad;
    ld_d_c   = ld_e_c ? '0 : ld_aligned;
    st_e_c   = req && mem_write && bad;

    ld_v_p_d = ld_v_c;
    ld_e_p_d = ld_e_c;
    ld_d_p_d = ld_d_c;

    if (RD_LAT == 2) begin
      ld_v_f = ld_v_p_q;
      ld_e_f = ld_e_p_q;
      ld_d_f = ld_d_p_q;
    end else begin
      ld_v_f = ld_v_c;
      ld_e_f = ld_e_c;
      ld_d_f = ld_d_c;
    end

    rdata_valid_d = ld_v_f;
    rdata_d       = ld_v_f ? ld_d_f : rdata_q;
    err_d         = st_e_c || ld_e_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= INIT;
      sweep_idx_q   <= '0;
      ld_v_p_q      <= 1'b0;
      ld_e_p_q      <= 1'b0;
      ld_d_p_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_idx_q   <= sweep_idx_d;
      ld_v_p_q      <= ld_v_p_d;
      ld_e_p_q      <= ld_e_p_d;
      ld_d_p_q      <= ld_d_p_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      err_q         <= err_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;
  assign ready       = (state_q == IDLE);

endmodule
